alu_op_sequencer: RTL and testbench

//  Hardware control sequencer for the bus datapath. Drives the out/in strobes,

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/onehot_dec4.sv | 16 +
 rtl/alu_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the ALU op sequencer: FSM states, IR field positions and opcodes.
// The IR field helper keeps the bit slicing in one place for the top level.
package cpu_ctrl_pkg;

   localparam int NREG = 16;
   localparam int NALU = 12;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   typedef logic [4:0] opcode_t;
   typedef logic [3:0] reg_idx_t;

   localparam opcode_t OP_OR  = 5'd9;
   localparam opcode_t OP_MUL = 5'd10;
   localparam opcode_t OP_DIV = 5'd11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_DONE,
      S_ILL
   } state_t;

   typedef struct packed {
      opcode_t  op;
      reg_idx_t ra;
      reg_idx_t rb;
      reg_idx_t rc;
   } ir_fields_t;

   // Takes only the decoded upper slice of IR; the low bits carry no control meaning.
   function automatic ir_fields_t ir_decode(input logic [OP_MSB:RC_LSB] f);
      ir_fields_t r;
      r.op = f[OP_MSB:OP_LSB];
      r.ra = f[RA_MSB:RA_LSB];
      r.rb = f[RB_MSB:RB_LSB];
      r.rc = f[RC_MSB:RC_LSB];
      return r;
   endfunction

endpackage

// File: rtl/onehot_dec4.sv
// 4-bit index to 16-bit one-hot decoder with enable; purely combinational.
// All-zero output when disabled, so at most one bit is ever set.
module onehot_dec4 (
   input  logic [3:0]  idx,
   input  logic        en,
   output logic [15:0] oh
);

   always_comb begin
      oh = '0;
      if (en) begin
         oh[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Fetch + 3-register ALU op sequencer (T0..T5); done 7 cycles after start is sampled, mem_rdy stalls T1.
// Optional SEQ_MULDIV_EN makes opcodes 10/11 legal and adds a T6 HI phase (done one cycle later).
module alu_op_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NREG = cpu_ctrl_pkg::NREG,
   parameter int NALU = cpu_ctrl_pkg::NALU
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic            mem_rdy,
   input  logic [31:0]     ir,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic            PCout,
   output logic            MARin,
   output logic            IncPC,
   output logic            Zin,
   output logic            Zlowout,
   output logic            Zhighout,
   output logic            PCin,
   output logic            MDRRead,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Yin,
   output logic            HIin,
   output logic            LOin,
   output logic [NREG-1:0] Rout,
   output logic [NREG-1:0] Rin,
   output logic [NALU-1:0] ALUControl
);

   state_t     state_q, state_d;
   ir_fields_t fld_q, fld_d;
   ir_fields_t ir_f;
   logic       ir_legal;
   logic       muldiv;
   logic       ir_unused;

   logic       rout_en;
   reg_idx_t   rout_idx;
   logic       rin_en;
   logic [15:0] rout_oh;
   logic [15:0] rin_oh;

   assign ir_f      = ir_decode(ir[OP_MSB:RC_LSB]);
   assign ir_unused = ^ir[RC_LSB-1:0];

`ifdef SEQ_MULDIV_EN
   assign ir_legal = (int'(ir_f.op) < NALU);
   assign muldiv   = (fld_q.op == OP_MUL) || (fld_q.op == OP_DIV);
`else
   assign ir_legal = (int'(ir_f.op) < NALU) && (ir_f.op != OP_MUL) && (ir_f.op != OP_DIV);
   assign muldiv   = 1'b0;
`endif

   // IR only holds the new instruction once T2's IRin edge has passed, so T3 reads ir live.
   always_comb begin
      state_d = state_q;
      fld_d   = fld_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_T0;
            end
         end
         S_T0: state_d = S_T1;
         S_T1: begin
            if (mem_rdy) begin
               state_d = S_T2;
            end
         end
         S_T2: state_d = S_T3;
         S_T3: begin
            fld_d   = ir_f;
            state_d = ir_legal ? S_T4 : S_ILL;
         end
         S_T4: state_d = S_T5;
         S_T5: state_d = muldiv ? S_T6 : S_DONE;
         S_T6: state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         S_ILL: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         fld_q   <= '0;
      end else begin
         state_q <= state_d;
         fld_q   <= fld_d;
      end
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      illegal    = (state_q == S_ILL);
      PCout      = 1'b0;
      MARin      = 1'b0;
      IncPC      = 1'b0;
      Zin        = 1'b0;
      Zlowout    = 1'b0;
      Zhighout   = 1'b0;
      PCin       = 1'b0;
      MDRRead    = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      ALUControl = '0;
      rout_en    = 1'b0;
      rout_idx   = fld_q.rc;
      rin_en     = 1'b0;
      case (state_q)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            MDRRead = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Yin      = 1'b1;
            rout_en  = 1'b1;
            rout_idx = ir_f.rb;
         end
         S_T4: begin
            Zin        = 1'b1;
            rout_en    = 1'b1;
            ALUControl = NALU'(1) << fld_q.op;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (muldiv) begin
               LOin = 1'b1;
            end else begin
               rin_en = 1'b1;
            end
         end
`ifdef SEQ_MULDIV_EN
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   onehot_dec4 u_rout_dec (
      .idx (rout_idx),
      .en  (rout_en),
      .oh  (rout_oh)
   );

   onehot_dec4 u_rin_dec (
      .idx (fld_q.ra),
      .en  (rin_en),
      .oh  (rin_oh)
   );

   assign Rout = rout_oh[NREG-1:0];
   assign Rin  = rin_oh[NREG-1:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: every cycle of each instruction is compared against
// hand-computed strobe vectors; define SEQ_MULDIV_EN to select the MUL/DIV expectations.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        clr, start, mem_rdy;
   logic [31:0] ir;
   logic        busy, done, illegal;
   logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
   logic        MDRRead, MDRin, MDRout, IRin, Yin, HIin, LOin;
   logic [15:0] Rout, Rin;
   logic [11:0] ALUControl;

   int checks   = 0;
   int failures = 0;

   localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4, P_T4 = 5;
   localparam int P_T5 = 6, P_T6 = 7, P_DONE = 8, P_ILL = 9;

   localparam logic [13:0] B_PCOUT = 14'h2000, B_MARIN = 14'h1000, B_INCPC = 14'h0800;
   localparam logic [13:0] B_ZIN = 14'h0400, B_ZLOW = 14'h0200, B_ZHIGH = 14'h0100;
   localparam logic [13:0] B_PCIN = 14'h0080, B_MDRREAD = 14'h0040, B_MDRIN = 14'h0020;
   localparam logic [13:0] B_MDROUT = 14'h0010, B_IRIN = 14'h0008, B_YIN = 14'h0004;
   localparam logic [13:0] B_HIIN = 14'h0002, B_LOIN = 14'h0001;

   // Hand-computed per-instruction values for the T3/T4/T5 register selects and ALU op.
   logic [15:0] e_rout3, e_rout4, e_rin5;
   logic [11:0] e_alu4;
   logic        e_md;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .mem_rdy    (mem_rdy),
      .ir         (ir),
      .busy       (busy),
      .done       (done),
      .illegal    (illegal),
      .PCout      (PCout),
      .MARin      (MARin),
      .IncPC      (IncPC),
      .Zin        (Zin),
      .Zlowout    (Zlowout),
      .Zhighout   (Zhighout),
      .PCin       (PCin),
      .MDRRead    (MDRRead),
      .MDRin      (MDRin),
      .MDRout     (MDRout),
      .IRin       (IRin),
      .Yin        (Yin),
      .HIin       (HIin),
      .LOin       (LOin),
      .Rout       (Rout),
      .Rin        (Rin),
      .ALUControl (ALUControl)
   );

   function automatic logic [63:0] snap();
      return {3'b000, busy, done, illegal,
              PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
              MDRRead, MDRin, MDRout, IRin, Yin, HIin, LOin,
              ALUControl, Rin, Rout};
   endfunction

   function automatic logic [63:0] mk(input logic b, input logic d, input logic il,
                                      input logic [13:0] s, input logic [11:0] a,
                                      input logic [15:0] ri, input logic [15:0] ro);
      return {3'b000, b, d, il, s, a, ri, ro};
   endfunction

   function automatic logic [63:0] exp_ph(input int ph);
      logic        b  = 1'b1;
      logic        d  = 1'b0;
      logic        il = 1'b0;
      logic [13:0] s  = '0;
      logic [11:0] a  = '0;
      logic [15:0] ri = '0;
      logic [15:0] ro = '0;
      case (ph)
         P_IDLE: b = 1'b0;
         P_T0:   s = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
         P_T1:   s = B_ZLOW | B_PCIN | B_MDRREAD | B_MDRIN;
         P_T2:   s = B_MDROUT | B_IRIN;
         P_T3: begin
            s  = B_YIN;
            ro = e_rout3;
         end
         P_T4: begin
            s  = B_ZIN;
            a  = e_alu4;
            ro = e_rout4;
         end
         P_T5: begin
            s  = B_ZLOW | (e_md ? B_LOIN : 14'h0000);
            ri = e_md ? 16'h0000 : e_rin5;
         end
         P_T6:   s  = B_ZHIGH | B_HIIN;
         P_DONE: d  = 1'b1;
         P_ILL:  il = 1'b1;
         default: b = 1'b0;
      endcase
      return mk(b, d, il, s, a, ri, ro);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic set_exp(input logic [15:0] r3, input logic [15:0] r4,
                          input logic [11:0] a4, input logic [15:0] r5);
      e_rout3 = r3;
      e_rout4 = r4;
      e_alu4  = a4;
      e_rin5  = r5;
   endtask

   // kind: 0 ALU op, 1 MUL/DIV, 2 illegal.  hold: 0 drop start after T0, 1 keep high, 2 drop at DONE.
   task automatic run_instr(input string tag, input logic [31:0] irv, input int stall,
                            input int kind, input int hold, input int exp_lat);
      int ph[$];
      int done_k = 0;
      ph.push_back(P_T0);
      for (int i = 0; i <= stall; i++) ph.push_back(P_T1);
      ph.push_back(P_T2);
      ph.push_back(P_T3);
      if (kind == 2) begin
         ph.push_back(P_ILL);
      end else begin
         ph.push_back(P_T4);
         ph.push_back(P_T5);
         if (kind == 1) ph.push_back(P_T6);
         ph.push_back(P_DONE);
      end
      ph.push_back(P_IDLE);
      e_md    = (kind == 1);
      ir      = irv;
      mem_rdy = (stall == 0);
      start   = 1'b1;
      for (int k = 1; k <= ph.size(); k++) begin
         @(negedge clk);
         if (done && done_k == 0) done_k = k;
         check_eq($sformatf("%s_k%0d", tag, k), snap(), exp_ph(ph[k-1]));
         if (k == 1 && hold == 0) start = 1'b0;
         if (ph[k-1] == P_DONE && hold == 2) start = 1'b0;
         if (k == 2 + stall) mem_rdy = 1'b1;
         if (ph[k-1] == P_T4) ir = 32'hFFFF_FFFF;
      end
      check_eq({tag, "_lat"}, 64'(done_k), 64'(exp_lat));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr     = 1'b1;
      start   = 1'b0;
      mem_rdy = 1'b1;
      ir      = 32'h0;
      e_md    = 1'b0;
      set_exp(16'h0, 16'h0, 12'h0, 16'h0);

      #2 clr = 1'b0;
      start  = 1'b1;
      #1 check_eq("reset_async", snap(), 64'd0);
      repeat (2) @(negedge clk);
      check_eq("reset_hold", snap(), 64'd0);
      start = 1'b0;
      clr   = 1'b1;
      @(negedge clk);
      check_eq("idle_after_reset", snap(), 64'd0);

      // OR R5 <= R2 | R4
      set_exp(16'h0004, 16'h0010, 12'h200, 16'h0020);
      run_instr("t1_or", 32'h4A92_0000, 0, 0, 0, 7);

      run_instr("t2_stall", 32'h4A92_0000, 3, 0, 0, 10);

      // opcode 20, Ra=3 Rb=1 Rc=2
      set_exp(16'h0002, 16'h0, 12'h0, 16'h0);
      run_instr("t3_ill20", {5'd20, 4'd3, 4'd1, 4'd2, 15'd0}, 0, 2, 0, 0);

      // opcode 12 is the first value outside the ALU select range
      set_exp(16'h4000, 16'h0, 12'h0, 16'h0);
      run_instr("t3_ill12", {5'd12, 4'hF, 4'hE, 4'hD, 15'h7FFF}, 0, 2, 0, 0);

      // abort in T4
      set_exp(16'h0004, 16'h0010, 12'h200, 16'h0020);
      e_md    = 1'b0;
      ir      = 32'h4A92_0000;
      mem_rdy = 1'b1;
      start   = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check_eq($sformatf("t4_pre_k%0d", k), snap(), exp_ph(k));
         if (k == 1) start = 1'b0;
      end
      clr = 1'b0;
      #1 check_eq("t4_clr_async", snap(), 64'd0);
      @(negedge clk);
      check_eq("t4_clr_hold", snap(), 64'd0);
      clr = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("t4_no_done", snap(), 64'd0);
      end
      run_instr("t4_restart", 32'h4A92_0000, 0, 0, 0, 7);

      // start held high across two back-to-back instructions
      run_instr("t5_first", 32'h4A92_0000, 0, 0, 1, 7);
      run_instr("t5_second", 32'h4A92_0000, 0, 0, 2, 7);
      @(negedge clk);
      check_eq("t5_idle", snap(), 64'd0);

      // opcode 0 with Ra=Rb=Rc=R0
      set_exp(16'h0001, 16'h0001, 12'h001, 16'h0001);
      run_instr("t7_r0", 32'h0000_0000, 0, 0, 0, 7);

      // MUL: Ra=7 Rb=3 Rc=9; DIV: Ra=15 Rb=0 Rc=15
`ifdef SEQ_MULDIV_EN
      set_exp(16'h0008, 16'h0200, 12'h400, 16'h0);
      run_instr("t6_mul", {5'd10, 4'd7, 4'd3, 4'd9, 15'd0}, 0, 1, 0, 8);
      set_exp(16'h0001, 16'h8000, 12'h800, 16'h0);
      run_instr("t6_div", {5'd11, 4'hF, 4'h0, 4'hF, 15'd0}, 0, 1, 0, 8);
`else
      set_exp(16'h0008, 16'h0, 12'h0, 16'h0);
      run_instr("t6_mul", {5'd10, 4'd7, 4'd3, 4'd9, 15'd0}, 0, 2, 0, 0);
      set_exp(16'h0001, 16'h0, 12'h0, 16'h0);
      run_instr("t6_div", {5'd11, 4'hF, 4'h0, 4'hF, 15'd0}, 0, 2, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
